// File: rtl/mini_bone.sv
// mini_bone: Ethernet-framed remote Wishbone bridge. Decodes a request frame
// from the fabric sink, performs one classic Wishbone cycle on the master
// port, and returns a fixed-size 60-byte reply frame on the fabric source.
module mini_bone #(
  parameter logic [7:0]  g_class_mask    = 8'hFF,
  parameter logic [15:0] g_our_ethertype = 16'hA0A0
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        snk_cyc_i,
  input  logic        snk_stb_i,
  input  logic        snk_we_i,
  input  logic [15:0] snk_dat_i,
  input  logic [1:0]  snk_adr_i,
  input  logic [1:0]  snk_sel_i,
  output logic        snk_stall_o,
  output logic        snk_ack_o,
  output logic        src_cyc_o,
  output logic        src_stb_o,
  output logic        src_we_o,
  output logic [15:0] src_dat_o,
  output logic [1:0]  src_adr_o,
  output logic [1:0]  src_sel_o,
  input  logic        src_ack_i,
  input  logic        src_stall_i,
  output logic        master_cyc_o,
  output logic        master_stb_o,
  output logic        master_we_o,
  output logic [3:0]  master_sel_o,
  output logic [31:0] master_adr_o,
  output logic [31:0] master_dat_o,
  input  logic [31:0] master_dat_i,
  input  logic        master_ack_i
);

  typedef enum logic [2:0] {S_IDLE, S_RX, S_DROP, S_BUS, S_TX} state_t;
  state_t state, state_nxt;

  logic        seen_low, err, beat, start, rx_act, drop, tmo_hit;
  logic [3:0]  wcnt, widx;
  logic [7:0]  cls, flags, tmo;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] etype;
  logic [31:0] addr, wdat, rdat;
  logic [1:0]  status;
  logic [4:0]  tcnt;
  logic        unused_ok;

  assign unused_ok = &{1'b0, snk_we_i, snk_sel_i, src_ack_i, flags[7:5]};

  // Sink is held off only while the current request is being served.
  assign snk_stall_o = (state == S_BUS) || (state == S_TX);
  assign beat        = snk_cyc_i && snk_stb_i && !snk_stall_o;
  // A frame starts on the first cyc high after cyc was seen low, so a frame
  // queued behind a stalled reply is still picked up when we return to IDLE.
  assign start       = (state == S_IDLE) && snk_cyc_i && seen_low;
  assign rx_act      = start || (state == S_RX);
  assign widx        = start ? 4'd0 : wcnt;
  assign drop        = err || ((cls != 8'h00) && ((cls & g_class_mask) == 8'h00)) ||
                       ((wcnt >= 4'd7) && (etype != g_our_ethertype));
  assign tmo_hit     = (tmo == 8'hFF) && !master_ack_i;

  // State register.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RX;
      S_RX: begin
        if (drop)            state_nxt = S_DROP;
        else if (!snk_cyc_i) state_nxt = (wcnt >= 4'd12) ? S_BUS : S_DROP;
      end
      S_DROP: if (!snk_cyc_i) state_nxt = S_IDLE;
      S_BUS:  if (master_ack_i || tmo_hit) state_nxt = S_TX;
      S_TX:   if (!src_stall_i && (tcnt == 5'd30)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame capture, bus result latch and reply beat counter.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      seen_low  <= 1'b0;
      snk_ack_o <= 1'b0;
      err       <= 1'b0;
      cls       <= 8'h00;
      wcnt      <= 4'd0;
      dst_mac   <= '0;
      src_mac   <= '0;
      etype     <= '0;
      flags     <= '0;
      addr      <= '0;
      wdat      <= '0;
      rdat      <= '0;
      status    <= 2'b00;
      tmo       <= 8'h00;
      tcnt      <= 5'd0;
    end else begin
      if (!snk_cyc_i)  seen_low <= 1'b1;
      else if (start)  seen_low <= 1'b0;
      snk_ack_o <= beat;
      if (start) begin
        err  <= 1'b0;
        cls  <= 8'h00;
        wcnt <= 4'd0;
      end
      if (beat && rx_act) begin
        case (snk_adr_i)
          2'b00: begin
            if (widx < 4'd12) wcnt <= widx + 4'd1;
            case (widx)
              4'd0:  dst_mac[47:32] <= snk_dat_i;
              4'd1:  dst_mac[31:16] <= snk_dat_i;
              4'd2:  dst_mac[15:0]  <= snk_dat_i;
              4'd3:  src_mac[47:32] <= snk_dat_i;
              4'd4:  src_mac[31:16] <= snk_dat_i;
              4'd5:  src_mac[15:0]  <= snk_dat_i;
              4'd6:  etype          <= snk_dat_i;
              4'd7:  flags          <= snk_dat_i[7:0];
              4'd8:  addr[31:16]    <= snk_dat_i;
              4'd9:  addr[15:0]     <= snk_dat_i;
              4'd10: wdat[31:16]    <= snk_dat_i;
              4'd11: wdat[15:0]     <= snk_dat_i;
              default: ;
            endcase
          end
          2'b10: begin
            err <= snk_dat_i[1];
            cls <= snk_dat_i[15:8];
          end
          default: ;
        endcase
      end
      if (state == S_BUS) begin
        tmo <= tmo + 8'd1;
        if (master_ack_i) begin
          rdat   <= master_dat_i;
          status <= 2'b01;
        end else if (tmo_hit) begin
          rdat   <= 32'h0;
          status <= 2'b10;
        end
      end else begin
        tmo <= 8'h00;
      end
      if (state == S_TX) begin
        if (!src_stall_i) tcnt <= tcnt + 5'd1;
      end else begin
        tcnt <= 5'd0;
      end
    end
  end

  assign master_cyc_o = (state == S_BUS);
  assign master_stb_o = (state == S_BUS);
  assign master_we_o  = (state == S_BUS) && flags[4];
  assign master_sel_o = flags[3:0];
  assign master_adr_o = addr;
  assign master_dat_o = wdat;

  assign src_cyc_o = (state == S_TX);
  assign src_stb_o = (state == S_TX);
  assign src_we_o  = (state == S_TX);
  assign src_sel_o = (state == S_TX) ? 2'b11 : 2'b00;
  assign src_adr_o = ((state == S_TX) && (tcnt == 5'd0)) ? 2'b10 : 2'b00;

  // Reply word mux: status beat, swapped MACs, EtherType, status, read data, zero pad.
  always_comb begin
    src_dat_o = 16'h0000;
    if (state == S_TX) begin
      case (tcnt)
        5'd1:  src_dat_o = src_mac[47:32];
        5'd2:  src_dat_o = src_mac[31:16];
        5'd3:  src_dat_o = src_mac[15:0];
        5'd4:  src_dat_o = dst_mac[47:32];
        5'd5:  src_dat_o = dst_mac[31:16];
        5'd6:  src_dat_o = dst_mac[15:0];
        5'd7:  src_dat_o = g_our_ethertype;
        5'd8:  src_dat_o = {14'd0, status};
        5'd9:  src_dat_o = rdat[31:16];
        5'd10: src_dat_o = rdat[15:0];
        default: src_dat_o = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_bone.sv
// tb_mini_bone: directed table vectors plus hand-written sequences for
// timeout, truncation, back-to-back, reset-during-TX and a random write/read sweep.
`timescale 1ns/1ps
module tb_mini_bone;
  logic        clk_sys = 1'b0, rst_n = 1'b0;
  logic        snk_cyc_i = 0, snk_stb_i = 0, snk_we_i = 0;
  logic [15:0] snk_dat_i = 0;
  logic [1:0]  snk_adr_i = 0, snk_sel_i = 0;
  logic        snk_stall_o, snk_ack_o;
  logic        src_cyc_o, src_stb_o, src_we_o;
  logic [15:0] src_dat_o;
  logic [1:0]  src_adr_o, src_sel_o;
  logic        src_ack_i = 1'b0, src_stall_i = 1'b0;
  logic        master_cyc_o, master_stb_o, master_we_o;
  logic [3:0]  master_sel_o;
  logic [31:0] master_adr_o, master_dat_o;
  logic [31:0] master_dat_i = 32'h0;
  logic        master_ack_i = 1'b0;

  always #5 clk_sys = ~clk_sys;

  mini_bone #(.g_class_mask(8'h0F), .g_our_ethertype(16'hA0A0)) dut (
    .clk_sys_i(clk_sys), .rst_n_i(rst_n),
    .snk_cyc_i(snk_cyc_i), .snk_stb_i(snk_stb_i), .snk_we_i(snk_we_i),
    .snk_dat_i(snk_dat_i), .snk_adr_i(snk_adr_i), .snk_sel_i(snk_sel_i),
    .snk_stall_o(snk_stall_o), .snk_ack_o(snk_ack_o),
    .src_cyc_o(src_cyc_o), .src_stb_o(src_stb_o), .src_we_o(src_we_o),
    .src_dat_o(src_dat_o), .src_adr_o(src_adr_o), .src_sel_o(src_sel_o),
    .src_ack_i(src_ack_i), .src_stall_i(src_stall_i),
    .master_cyc_o(master_cyc_o), .master_stb_o(master_stb_o), .master_we_o(master_we_o),
    .master_sel_o(master_sel_o), .master_adr_o(master_adr_o), .master_dat_o(master_dat_o),
    .master_dat_i(master_dat_i), .master_ack_i(master_ack_i)
  );

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Memory slave with random ack latency; writes return 0 on the data bus.
  logic [31:0] mem [0:255];
  bit          mem_en = 1'b1;
  int          lat = 0;
  logic        last_we = 1'b0;
  logic [3:0]  last_sel = 4'h0;
  logic [31:0] last_adr = 32'h0, last_dat = 32'h0;
  always @(negedge clk_sys) begin
    if (master_ack_i) master_ack_i = 1'b0;
    else if (mem_en && master_cyc_o && master_stb_o) begin
      if (lat == 0) begin
        last_we = master_we_o; last_sel = master_sel_o;
        last_adr = master_adr_o; last_dat = master_dat_o;
        if (master_we_o) begin
          for (int b = 0; b < 4; b++)
            if (master_sel_o[b]) mem[master_adr_o[7:0]][b*8 +: 8] = master_dat_o[b*8 +: 8];
          master_dat_i = 32'h0;
        end else master_dat_i = mem[master_adr_o[7:0]];
        master_ack_i = 1'b1;
        lat = $urandom_range(0, 3);
      end else lat--;
    end
  end

  // Bus cycle, sink ack and reply monitors.
  int n_mcyc = 0, mrun = 0, last_run = 0, n_ack = 0, n_acc = 0;
  bit mprev = 1'b0;
  always @(negedge clk_sys) begin
    if (master_cyc_o) begin
      if (!mprev) begin n_mcyc++; mrun = 0; end
      mrun++;
    end else if (mprev) last_run = mrun;
    mprev = master_cyc_o;
    if (snk_ack_o) n_ack++;
  end

  logic [20:0] rq[$];
  always @(negedge clk_sys)
    if (src_cyc_o && src_stb_o && !src_stall_i)
      rq.push_back({src_we_o, src_sel_o, src_adr_o, src_dat_o});

  bit src_thr = 1'b0, snk_thr = 1'b0;
  always @(posedge clk_sys) begin
    #1;
    src_stall_i = src_thr && ($urandom_range(0, 9) == 0);
  end

  task automatic clear_stats();
    n_mcyc = 0; n_ack = 0; n_acc = 0; rq.delete();
  endtask

  task automatic beat(input logic [1:0] a, input logic [15:0] d);
    int g;
    @(negedge clk_sys);
    if (snk_thr && ($urandom_range(0, 9) == 0)) begin
      snk_stb_i = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk_sys);
    end
    snk_cyc_i = 1'b1; snk_stb_i = 1'b1; snk_we_i = 1'b1; snk_sel_i = 2'b11;
    snk_adr_i = a; snk_dat_i = d;
    g = 0;
    while (snk_stall_o && g < 5000) begin @(negedge clk_sys); g++; end
    if (g >= 5000) chk("sink_stall_timeout", 64'(g), 64'd0);
    n_acc++;
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] et, input logic [15:0] stw,
                            input logic [7:0] fl, input logic [31:0] a,
                            input logic [31:0] d, input int nw);
    logic [15:0] w [0:15];
    w[0] = dst[47:32]; w[1] = dst[31:16]; w[2] = dst[15:0];
    w[3] = src[47:32]; w[4] = src[31:16]; w[5] = src[15:0];
    w[6] = et; w[7] = {8'h00, fl};
    w[8] = a[31:16]; w[9] = a[15:0]; w[10] = d[31:16]; w[11] = d[15:0];
    for (int i = 12; i < 16; i++) w[i] = 16'hC0DE;
    beat(2'b10, stw);
    for (int i = 0; i < nw; i++) beat(2'b00, w[i]);
    beat(2'b01, 16'h5A5A);
    @(negedge clk_sys);
    snk_cyc_i = 1'b0; snk_stb_i = 1'b0;
  endtask

  task automatic wait_reply(input string nm, input int n);
    int g = 0;
    while (!(rq.size() >= n && !src_cyc_o) && g < 4000) begin @(negedge clk_sys); g++; end
    repeat (3) @(negedge clk_sys);
    chk({nm, "_len"}, 64'(rq.size()), 64'(n));
  endtask

  task automatic check_reply(input string nm, input logic [47:0] dst, input logic [47:0] src,
                             input logic [1:0] st, input logic [31:0] rd);
    logic [20:0] e, got, bv, bx;
    logic [15:0] d, gst;
    logic [31:0] grd;
    bit bad = 1'b0;
    gst = 16'hFFFF; grd = 32'hFFFF_FFFF; bv = '0; bx = '0;
    for (int k = 0; k < 31; k++) begin
      case (k)
        1: d = src[47:32];  2: d = src[31:16];  3: d = src[15:0];
        4: d = dst[47:32];  5: d = dst[31:16];  6: d = dst[15:0];
        7: d = 16'hA0A0;    8: d = {14'd0, st};
        9: d = rd[31:16];   10: d = rd[15:0];
        default: d = 16'h0000;
      endcase
      e = {1'b1, 2'b11, (k == 0) ? 2'b10 : 2'b00, d};
      got = (rq.size() > 0) ? rq.pop_front() : 21'h0;
      if (k == 8)  gst = got[15:0];
      if (k == 9)  grd[31:16] = got[15:0];
      if (k == 10) grd[15:0]  = got[15:0];
      if (k == 0 || (!bad && got !== e)) begin bv = got; bx = e; end
      if (got !== e) bad = 1'b1;
    end
    chk({nm, "_status"}, 64'(gst), 64'({14'd0, st}));
    chk({nm, "_rdata"}, 64'(grd), 64'(rd));
    chk({nm, "_beat"}, 64'(bv), 64'(bx));
  endtask

  typedef struct {
    logic [15:0] et;
    logic [15:0] stw;
    logic [7:0]  fl;
    logic [31:0] adr;
    logic [31:0] dat;
    bit          rep;
    logic [1:0]  st;
    logic [31:0] rd;
  } vec_t;
  vec_t vt [0:8];

  task automatic run_vec(input vec_t v, input int idx);
    logic [47:0] dm, sm;
    string nm;
    nm = $sformatf("vec%0d", idx);
    dm = {16'h0200, 32'(idx)};
    sm = {16'h0A0B, 32'(idx * 3 + 1)};
    clear_stats();
    send_frame(dm, sm, v.et, v.stw, v.fl, v.adr, v.dat, 14);
    if (v.rep) begin
      wait_reply(nm, 31);
      check_reply(nm, dm, sm, v.st, v.rd);
      chk({nm, "_ncyc"}, 64'(n_mcyc), 64'd1);
      chk({nm, "_adr"}, 64'(last_adr), 64'(v.adr));
      chk({nm, "_sel"}, 64'(last_sel), 64'(v.fl[3:0]));
      chk({nm, "_we"}, 64'(last_we), 64'(v.fl[4]));
      if (v.fl[4]) chk({nm, "_wdat"}, 64'(last_dat), 64'(v.dat));
    end else begin
      repeat (40) @(negedge clk_sys);
      chk({nm, "_noreply"}, 64'(rq.size()), 64'd0);
      chk({nm, "_nocyc"}, 64'(n_mcyc), 64'd0);
    end
    chk({nm, "_acks"}, 64'(n_ack), 64'(n_acc));
  endtask

  logic [31:0] wd [0:99];
  int g;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    vt[0] = '{16'hA0A0, 16'h0000, 8'h1F, 32'h5,  32'h12345678, 1'b1, 2'b01, 32'h0};
    vt[1] = '{16'hA0A0, 16'h0000, 8'h0F, 32'h5,  32'h0,        1'b1, 2'b01, 32'h12345678};
    vt[2] = '{16'h0800, 16'h0000, 8'h1F, 32'h7,  32'h55AA55AA, 1'b0, 2'b00, 32'h0};
    vt[3] = '{16'hA0A0, 16'h0002, 8'h0F, 32'h5,  32'h0,        1'b0, 2'b00, 32'h0};
    vt[4] = '{16'hA0A0, 16'h1000, 8'h0F, 32'h5,  32'h0,        1'b0, 2'b00, 32'h0};
    vt[5] = '{16'hA0A0, 16'h0300, 8'h0F, 32'h5,  32'h0,        1'b1, 2'b01, 32'h12345678};
    vt[6] = '{16'hA0A0, 16'h0000, 8'h13, 32'h10, 32'hDEADBEEF, 1'b1, 2'b01, 32'h0};
    vt[7] = '{16'hA0A0, 16'h0000, 8'h0F, 32'h10, 32'h0,        1'b1, 2'b01, 32'h0000BEEF};
    vt[8] = '{16'hA0A0, 16'h0000, 8'h0F, 32'h7,  32'h0,        1'b1, 2'b01, 32'h0};

    // Reset state.
    repeat (3) @(negedge clk_sys);
    chk("rst_snk_stall", 64'(snk_stall_o), 64'd0);
    chk("rst_snk_ack", 64'(snk_ack_o), 64'd0);
    chk("rst_src_cyc", 64'(src_cyc_o), 64'd0);
    chk("rst_src_dat", 64'(src_dat_o), 64'd0);
    chk("rst_master_cyc", 64'(master_cyc_o), 64'd0);
    chk("rst_master_we", 64'(master_we_o), 64'd0);
    chk("rst_master_adr", 64'(master_adr_o), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_sys);

    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    // Memory never acks: 256-cycle timeout, error status, zero data.
    mem_en = 1'b0;
    clear_stats();
    send_frame(48'h020000000099, 48'h0A0B00000077, 16'hA0A0, 16'h0, 8'h0F, 32'h5, 32'h0, 12);
    wait_reply("tmo", 31);
    check_reply("tmo", 48'h020000000099, 48'h0A0B00000077, 2'b10, 32'h0);
    chk("tmo_cycles", 64'(last_run), 64'd256);
    chk("tmo_ncyc", 64'(n_mcyc), 64'd1);
    mem_en = 1'b1;

    // Cyc falls before W11: dropped, fully acked.
    clear_stats();
    send_frame(48'h1, 48'h2, 16'hA0A0, 16'h0, 8'h1F, 32'h7, 32'hFFFFFFFF, 10);
    repeat (40) @(negedge clk_sys);
    chk("trunc_noreply", 64'(rq.size()), 64'd0);
    chk("trunc_nocyc", 64'(n_mcyc), 64'd0);
    chk("trunc_acks", 64'(n_ack), 64'(n_acc));

    // Back-to-back: second frame is held off by stall until the first reply is out.
    src_thr = 1'b1; snk_thr = 1'b1;
    clear_stats();
    send_frame(48'h111111111111, 48'h222222222222, 16'hA0A0, 16'h0, 8'h1F, 32'h20, 32'hCAFEF00D, 12);
    send_frame(48'h333333333333, 48'h444444444444, 16'hA0A0, 16'h0, 8'h0F, 32'h20, 32'h0, 12);
    wait_reply("b2b", 62);
    check_reply("b2bA", 48'h111111111111, 48'h222222222222, 2'b01, 32'h0);
    check_reply("b2bB", 48'h333333333333, 48'h444444444444, 2'b01, 32'hCAFEF00D);
    chk("b2b_ncyc", 64'(n_mcyc), 64'd2);
    chk("b2b_acks", 64'(n_ack), 64'(n_acc));

    // Reset during TX aborts the reply; the next request is answered normally.
    src_thr = 1'b0; snk_thr = 1'b0;
    clear_stats();
    send_frame(48'h5, 48'h6, 16'hA0A0, 16'h0, 8'h0F, 32'h5, 32'h0, 12);
    g = 0;
    while (rq.size() < 5 && g < 2000) begin @(negedge clk_sys); g++; end
    chk("rst_tx_pre_cyc", 64'(src_cyc_o), 64'd1);
    rst_n = 1'b0;
    @(posedge clk_sys); #1;
    chk("rst_tx_src_cyc", 64'(src_cyc_o), 64'd0);
    chk("rst_tx_stall", 64'(snk_stall_o), 64'd0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    clear_stats();
    repeat (3) @(negedge clk_sys);
    send_frame(48'h7, 48'h8, 16'hA0A0, 16'h0, 8'h0F, 32'h20, 32'h0, 12);
    wait_reply("post_rst", 31);
    check_reply("post_rst", 48'h7, 48'h8, 2'b01, 32'hCAFEF00D);

    // Random sweep with throttling on both fabric sides.
    src_thr = 1'b1; snk_thr = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wd[i] = $urandom;
      clear_stats();
      send_frame(48'hAA0000000000 + 48'(i), 48'hBB0000000000 + 48'(i), 16'hA0A0, 16'h0,
                 8'h1F, 32'h100 + 32'(i), wd[i], 12);
      wait_reply($sformatf("rw%0d", i), 31);
      check_reply($sformatf("rw%0d", i), 48'hAA0000000000 + 48'(i), 48'hBB0000000000 + 48'(i),
                  2'b01, 32'h0);
    end
    for (int i = 0; i < 100; i++) begin
      clear_stats();
      send_frame(48'hCC0000000000 + 48'(i), 48'hDD0000000000 + 48'(i), 16'hA0A0, 16'h0,
                 8'h0F, 32'h100 + 32'(i), 32'h0, 12);
      wait_reply($sformatf("rr%0d", i), 31);
      check_reply($sformatf("rr%0d", i), 48'hCC0000000000 + 48'(i), 48'hDD0000000000 + 48'(i),
                  2'b01, wd[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mini_bone.md
MINI_BONE -- requirements
Module: mini_bone

Interface
REQ-001 g_class_mask, 8'hFF, classes accepted (class field of status word ANDed with mask).
REQ-002 g_our_ethertype, 16'hA0A0, EtherType of request and reply frames.
REQ-003 clk_sys_i  in  1  single system clock; all logic on rising edge.
REQ-004 rst_n_i  in  1  reset, synchronous and active-low.
REQ-005 snk_cyc_i, snk_stb_i, snk_we_i  in  1 each  fabric sink cycle, strobe, write.
REQ-006 snk_dat_i  in  16; snk_adr_i  in  2 (00 data, 01 OOB, 10 status, 11 user); snk_sel_i  in  2.
REQ-007 snk_stall_o, snk_ack_o  out  1 each  sink flow control and acknowledge.
REQ-008 src_cyc_o, src_stb_o, src_we_o  out  1; src_dat_o  out  16; src_adr_o  out  2; src_sel_o  out  2.
REQ-009 src_ack_i, src_stall_i  in  1 each  source acknowledge and stall.
REQ-010 master_cyc_o, master_stb_o, master_we_o  out  1; master_sel_o  out  4; master_adr_o, master_dat_o  out  32.
REQ-011 master_dat_i  in  32; master_ack_i  in  1  memory-side classic Wishbone return path.

Function
REQ-012 Frame format, 16-bit big-endian words on sink: W0-2 dst MAC, W3-5 src MAC, W6 EtherType, W7 = {payload0, flags}, W8-9 address[31:0], W10-11 data[31:0]; further words ignored.
REQ-013 Flags byte: bit4 = write (1) / read (0); bits3:0 = byte select.
REQ-014 Sink: every accepted beat (cyc & stb & !stall) is acked with snk_ack_o exactly one cycle later; snk_adr_i 01/11 beats are acked and discarded.
REQ-015 Sink: a status beat (adr 10) sets frame error from bit1 and class from bits15:8.
REQ-016 Frame drop conditions: error bit set; class nonzero and (class & g_class_mask)==0; EtherType != g_our_ethertype; or cyc falls before W11.
REQ-017 A dropped frame is fully acked; no bus cycle is performed and no reply is sent.
REQ-018 snk_stall_o is 0 in IDLE/RX and 1 from end of a valid frame until the reply has been transmitted.
REQ-019 States: IDLE -> RX on snk_cyc_i rise.
REQ-020 RX -> DROP on drop condition; DROP -> IDLE on cyc fall.
REQ-021 RX -> BUS on cyc fall with valid frame; BUS -> TX on master_ack_i or timeout; TX -> IDLE after last beat.
REQ-022 BUS: assert master_cyc/stb with adr = address, dat = data, sel = flags[3:0], we = flags[4]; hold until master_ack_i.
REQ-023 BUS: on master_ack_i, latch master_dat_i, drop cyc/stb the same edge, set status = 01 (ack).
REQ-024 BUS timeout: 256 cycles without ack -> deassert master_cyc/stb, status = 10 (error), read data = 0.
REQ-025 Reply: one status beat (adr 10, dat 0) then 30 data beats (adr 00, sel 11): dst = request src MAC, src = request dst MAC, EtherType = g_our_ethertype.
REQ-026 Reply payload: byte0 = 0, byte1 = {6'b0, status}, bytes2-5 = latched read data big-endian, bytes6-45 = 0 (60-byte frame, no CRC).
REQ-027 TX: src_cyc_o and src_stb_o high; data advances only when src_stall_i = 0; src_we_o = 1.
REQ-028 TX: src_cyc_o drops the cycle after the last beat is accepted; src_ack_i is ignored for flow.
REQ-029 Back-to-back requests are processed in order; a new frame is not accepted until TX completes (enforced by stall).

Reset
REQ-030 While rst_n_i = 0 at a rising edge: state IDLE.
REQ-031 Reset values: all cyc/stb/we/ack outputs 0, snk_stall_o 0, data/address outputs 0, latched fields cleared.
REQ-032 Reset mid-frame or mid-bus-cycle aborts the operation without reply; first frame after reset is decoded normally.

Verification
REQ-033 Write request addr 0x00000005, data 0x12345678, flags 0x1F -> one memory write, sel F, adr 5; reply byte1 = 0x01.
REQ-034 Read request addr 5, flags 0x0F -> reply bytes2-5 = 12 34 56 78, byte1 = 0x01.
REQ-035 Frame with EtherType 0x0800 -> all beats acked, no master_cyc_o, no reply.
REQ-036 Memory never acks -> master_cyc_o drops after 256 cycles; reply byte1 = 0x02, data 0.
REQ-037 100 random writes then 100 reads, 10% source throttling and 10% sink stalls of 1-3 cycles -> every readback matches, reply length 31 beats each.
REQ-038 Reset asserted during TX -> src_cyc_o = 0 next edge; next request answered correctly.
